mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative multiply/divide execution unit downstream of the register bank.
//  Consumes the two read-port operands (Data1/Data2) and a destination address.
//  Computes one of MUL/MULH/DIV/REM over 32 iterations.
//  Returns the result on a one-cycle write port that drives the bank's Write/AddrWrite/DataIn.
// PARAMETERS
//  WIDTH  32  operand/result width; iteration count = WIDTH
//  AW     5   destination register address width
// PORTS
//  Clock      in   1      single clock, all state on posedge
//  Reset      in   1      synchronous, active-high
//  Start      in   1      request; accepted only when Busy=0
//  Op         in   2      00 MUL(lo), 01 MULH(hi, unsigned), 10 DIV, 11 REM
//  OperandA   in   WIDTH  multiplicand / dividend (bank Data1)
//  OperandB   in   WIDTH  multiplier / divisor (bank Data2)
//  DestAddr   in   AW     register to write with the result
//  Signed     in   1      only with MDU_SIGNED_EN: treat operands as two's complement
//  Busy       out  1      high from the cycle after accept through the Done cycle
//  Done       out  1      one-cycle pulse, result valid
//  WbWrite    out  1      equal to Done; drives bank Write
//  WbAddr     out  AW     latched DestAddr; drives bank AddrWrite
//  WbData     out  WIDTH  result; drives bank DataIn
// BEHAVIOUR
//  Reset: state=IDLE; Busy, Done, WbWrite = 0; WbAddr, WbData = 0; iteration counter = 0.
//  FSM IDLE -> RUN: on Start in IDLE, latch Op, operands and DestAddr; counter = 0.
//  FSM RUN -> RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle; counter++.
//  FSM RUN -> DONE: when counter == WIDTH-1 the final step completes.
//  FSM DONE -> IDLE: Done = WbWrite = 1 for exactly this cycle.
//  Latency: Start accepted in cycle 0 -> Done in cycle WIDTH+1 (33); next Start is accepted in cycle WIDTH+2.
//  Start while Busy is ignored; inputs are not sampled outside the accept cycle.
//  Operands change after accept: no effect on the result.
//  Multiply: 2*WIDTH product. MUL returns bits [WIDTH-1:0]; MULH returns [2*WIDTH-1:WIDTH].
//  Divide by zero: DIV = all ones; REM = dividend. The step is not attempted and no error is flagged.
//  WbAddr/WbData hold their last values after Done. WbWrite=0 outside Done.
//  DestAddr==0 is written like any other register; no filtering.
//  Reset mid-RUN or mid-DONE: abort immediately, no write issued, return to IDLE.
//  Reset and Start in the same cycle: Reset wins, Start is dropped.
// CONFIGURATION
//  MDU_SIGNED_EN defined:
//   - Signed port exists.
//   - When Signed=1, operands are converted to magnitudes at accept and the result sign is fixed in DONE.
//   - The quotient sign is signA^signB; the remainder takes the sign of the dividend.
//   - MUL/MULH produce a signed product.
//   - Overflow (INT_MIN / -1): DIV = INT_MIN, REM = 0.
//   - Div-by-zero rules unchanged.
//   - Latency unchanged.
//  MDU_SIGNED_EN undefined: Signed port absent; all ops unsigned.
// STRUCTURE
//  Shared package mdu_pkg: Op encodings (OP_MUL, OP_MULH, OP_DIV, OP_REM), FSM state encoding (IDLE/RUN/DONE), WIDTH/AW defaults.
//  One sub-module, mdu_step: combinational single-iteration datapath (add-shift or compare-subtract-shift).
//  The mul_div_unit top owns the FSM, counter, operand/accumulator registers and writeback registers.
// TESTING
//  1. MUL, A=7, B=6, DestAddr=3, Start at cycle 0 -> cycle 33: Done=WbWrite=1, WbAddr=3, WbData=42; cycle 34: WbWrite=0, Busy=0.
//  2. MULH, A=B=0xFFFFFFFF -> WbData=0xFFFFFFFE. MUL on the same operands -> 0x00000001.
//  3. DIV 100/7 -> 14; REM 100%7 -> 2. DIV 5/0 -> 0xFFFFFFFF; REM 5%0 -> 5.
//  4. Start pulsed again at cycles 1..32 with different operands -> one Done only, result from the cycle-0 operands; a new Start in cycle 34 is accepted.
//  5. Reset asserted at cycle 10 of a DIV -> no WbWrite ever; Busy=0 at cycle 11; a fresh MUL 3*3 then returns 9 at the normal latency.
//  6. (MDU_SIGNED_EN) Signed DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; 0x80000000/-1 -> 0x80000000, REM 0; Signed MUL -3*4 -> 0xFFFFFFF4.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state encodings,
// default operand and register-address widths.
package mdu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_AW    = 5;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIV  = 2'b10,
    OP_REM  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the mul/div datapath: shift-add for multiply, restoring
// compare-subtract-shift for divide. Purely combinational.
module mdu_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = '0;
    diff    = '0;
    hi_next = hi;
    lo_next = lo;
    if (!is_div) begin
      // hi:lo holds partial product over remaining multiplier bits
      sum                = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
      {hi_next, lo_next} = {sum, lo[WIDTH-1:1]};
    end else begin
      // hi is the partial remainder, lo shifts dividend out and quotient in
      diff = {hi, lo[WIDTH-1]} - {1'b0, b};
      if (!diff[WIDTH]) begin
        hi_next = diff[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = {hi[WIDTH-2:0], lo[WIDTH-1]};
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MUL/MULH/DIV/REM unit with a one-cycle register-bank write port.
// Define MDU_SIGNED_EN to add the Signed port and two's-complement operation.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned AW    = DEFAULT_AW
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic [AW-1:0]    DestAddr,
`ifdef MDU_SIGNED_EN
  input  logic             Signed,
`endif
  output logic             Busy,
  output logic             Done,
  output logic             WbWrite,
  output logic [AW-1:0]    WbAddr,
  output logic [WIDTH-1:0] WbData
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic [CW-1:0]    cnt_q;
  logic [AW-1:0]    addr_q, wb_addr_q;
  logic [WIDTH-1:0] wb_data_q;
  logic             busy_q, done_q;
  logic             bzero_q, neg_q, rem_neg_q;

  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem, result_c;

`ifdef MDU_SIGNED_EN
  assign sign_a = Signed & OperandA[WIDTH-1];
  assign sign_b = Signed & OperandB[WIDTH-1];
`else
  assign sign_a = 1'b0;
  assign sign_b = 1'b0;
`endif

  assign mag_a = sign_a ? -OperandA : OperandA;
  assign mag_b = sign_b ? -OperandB : OperandB;

  mdu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div  (op_q[1]),
    .hi      (hi_q),
    .lo      (lo_q),
    .b       (b_q),
    .hi_next (hi_n),
    .lo_next (lo_n)
  );

  // Result of the final step with signs restored; registered on entry to DONE.
  always_comb begin
    prod = {hi_n, lo_n};
    if (neg_q) prod = -prod;
    quo = lo_n;
    if (bzero_q)    quo = '1;
    else if (neg_q) quo = -lo_n;
    rem = rem_neg_q ? -hi_n : hi_n;
    result_c = '0;
    unique case (op_q)
      OP_MUL:  result_c = prod[WIDTH-1:0];
      OP_MULH: result_c = prod[2*WIDTH-1:WIDTH];
      OP_DIV:  result_c = quo;
      OP_REM:  result_c = rem;
      default: result_c = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      op_q      <= OP_MUL;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bzero_q   <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (Start) begin
            op_q      <= op_e'(Op);
            hi_q      <= '0;
            lo_q      <= mag_a;
            b_q       <= mag_b;
            addr_q    <= DestAddr;
            bzero_q   <= (OperandB == '0);
            neg_q     <= sign_a ^ sign_b;
            rem_neg_q <= sign_a;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          hi_q  <= hi_n;
          lo_q  <= lo_n;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            wb_data_q <= result_c;
            wb_addr_q <= addr_q;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign WbWrite = done_q;
  assign WbAddr  = wb_addr_q;
  assign WbData  = wb_data_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit; signed vectors run when MDU_SIGNED_EN is defined.
module tb_mul_div_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] OperandA, OperandB;
  logic [4:0]  DestAddr;
`ifdef MDU_SIGNED_EN
  logic        Signed;
`endif
  logic        Busy, Done, WbWrite;
  logic [4:0]  WbAddr;
  logic [31:0] WbData;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clock = ~Clock;

  mul_div_unit #(
    .WIDTH (32),
    .AW    (5)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .Op       (Op),
    .OperandA (OperandA),
    .OperandB (OperandB),
    .DestAddr (DestAddr),
`ifdef MDU_SIGNED_EN
    .Signed   (Signed),
`endif
    .Busy     (Busy),
    .Done     (Done),
    .WbWrite  (WbWrite),
    .WbAddr   (WbAddr),
    .WbData   (WbData)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle 34 (idle again).
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] addr,
                        input logic [31:0] exp, input bit spam);
    int cyc;
    Op = op; OperandA = a; OperandB = b; DestAddr = addr; Start = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Start = 1'b0;
    Op = op ^ 2'b01; OperandA = $urandom; OperandB = $urandom; DestAddr = ~addr;
    cyc = 1;
    check({tag, " busy"}, 64'(Busy), 64'd1);
    while (!Done && cyc < 40) begin
      Start = spam && cyc <= 32;
      if (spam) begin
        OperandA = $urandom;
        OperandB = $urandom;
      end
      @(negedge Clock);
      cyc++;
    end
    Start = 1'b0;
    check({tag, " latency"}, 64'(cyc), 64'd33);
    check({tag, " wbwrite"}, 64'(WbWrite), 64'd1);
    check({tag, " wbaddr"}, 64'(WbAddr), 64'(addr));
    check({tag, " wbdata"}, 64'(WbData), 64'(exp));
    @(negedge Clock);
    check({tag, " wbwrite off"}, 64'(WbWrite), 64'd0);
    check({tag, " idle"}, 64'(Busy), 64'd0);
    check({tag, " hold"}, 64'(WbData), 64'(exp));
  endtask

  initial begin
    int wr;
    Reset = 1'b1; Start = 1'b0; Op = 2'b00;
    OperandA = '0; OperandB = '0; DestAddr = '0;
`ifdef MDU_SIGNED_EN
    Signed = 1'b0;
`endif
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    check("rst busy", 64'(Busy), 64'd0);
    check("rst done", 64'(Done), 64'd0);
    check("rst wbwrite", 64'(WbWrite), 64'd0);
    check("rst wbaddr", 64'(WbAddr), 64'd0);
    check("rst wbdata", 64'(WbData), 64'd0);

    run_op("mul 7*6", 2'b00, 32'd7, 32'd6, 5'd3, 32'd42, 1'b0);
    run_op("mulh ff*ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'hFFFF_FFFE, 1'b0);
    run_op("mul ff*ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h0000_0001, 1'b0);
    run_op("div 100/7", 2'b10, 32'd100, 32'd7, 5'd31, 32'd14, 1'b0);
    run_op("rem 100%7", 2'b11, 32'd100, 32'd7, 5'd17, 32'd2, 1'b0);
    run_op("div 5/0", 2'b10, 32'd5, 32'd0, 5'd4, 32'hFFFF_FFFF, 1'b0);
    run_op("rem 5%0", 2'b11, 32'd5, 32'd0, 5'd5, 32'd5, 1'b0);
    run_op("div big/1", 2'b10, 32'hFFFF_FFFF, 32'd1, 5'd6, 32'hFFFF_FFFF, 1'b0);
    run_op("mulh 2^31*4", 2'b01, 32'h8000_0000, 32'd4, 5'd7, 32'd2, 1'b0);
    // Start hammered while busy; the back-to-back call checks accept in cycle 34
    run_op("mul busy-start", 2'b00, 32'd1000, 32'd1000, 5'd12, 32'd1000000, 1'b1);
    run_op("div after spam", 2'b10, 32'd1000, 32'd10, 5'd13, 32'd100, 1'b0);

    // Reset in cycle 10 of a divide
    Op = 2'b10; OperandA = 32'd1000; OperandB = 32'd3; DestAddr = 5'd8; Start = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Start = 1'b0;
    repeat (9) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("abort busy", 64'(Busy), 64'd0);
    check("abort wbdata", 64'(WbData), 64'd0);
    wr = 0;
    repeat (40) begin
      @(negedge Clock);
      if (WbWrite) wr++;
    end
    check("abort no write", 64'(wr), 64'd0);
    run_op("mul 3*3", 2'b00, 32'd3, 32'd3, 5'd1, 32'd9, 1'b0);

    // Reset and Start together: Start dropped
    Reset = 1'b1; Start = 1'b1; Op = 2'b00; OperandA = 32'd2; OperandB = 32'd2;
    @(negedge Clock);
    Reset = 1'b0; Start = 1'b0;
    @(negedge Clock);
    check("rst+start busy", 64'(Busy), 64'd0);

`ifdef MDU_SIGNED_EN
    Signed = 1'b1;
    run_op("sdiv -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFD, 1'b0);
    run_op("srem -7%2", 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 1'b0);
    run_op("sdiv ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h8000_0000, 1'b0);
    run_op("srem ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'd0, 1'b0);
    run_op("smul -3*4", 2'b00, 32'hFFFF_FFFD, 32'd4, 5'd4, 32'hFFFF_FFF4, 1'b0);
    run_op("smulh -3*4", 2'b01, 32'hFFFF_FFFD, 32'd4, 5'd4, 32'hFFFF_FFFF, 1'b0);
    run_op("sdiv -5/0", 2'b10, 32'hFFFF_FFFB, 32'd0, 5'd5, 32'hFFFF_FFFF, 1'b0);
    run_op("srem -5%0", 2'b11, 32'hFFFF_FFFB, 32'd0, 5'd5, 32'hFFFF_FFFB, 1'b0);
    Signed = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
